// File: rtl/norm_pkg.sv
// Shared types for the shift normalizer: FSM state encoding and shift-direction constants.
// Direction encoding matches the barrel shifter so the two blocks can share a dir wire.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_normalizer_if.sv
// Producer/consumer handshake bundle for shift_normalizer.
// NORM_DIR_EN adds the in_dir lane carried alongside in_data.
interface shift_normalizer_if #(
    parameter int DEPTH = 8
);
    localparam int LOG2 = $clog2(DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [DEPTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DEPTH-1:0]  out_data;
    logic [LOG2-1:0]   out_shamt;
    logic              out_zero;

`ifdef NORM_DIR_EN
    logic              in_dir;

    modport master (
        output in_valid, in_data, in_dir, out_ready,
        input  in_ready, out_valid, out_data, out_shamt, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_dir, out_ready,
        output in_ready, out_valid, out_data, out_shamt, out_zero
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shamt, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shamt, out_zero
    );
`endif

endinterface

// File: rtl/norm_stage.sv
// One binary-search normalization stage: tests the top (left) or bottom (right) 2^k bits
// and shifts the word by 2^k with zero fill when they are all zero.
module norm_stage
    import norm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         word,
    input  logic [$clog2(DEPTH)-1:0] k,
    input  logic                     dir,
    output logic [DEPTH-1:0]         shifted,
    output logic                     take
);

    localparam int LOG2 = $clog2(DEPTH);

    logic [LOG2:0]      amt;
    logic [DEPTH-1:0]   top_mask;
    logic [DEPTH-1:0]   bot_mask;

    assign amt      = {{LOG2{1'b0}}, 1'b1} << k;
    assign top_mask = ~({DEPTH{1'b1}} >> amt);
    assign bot_mask = ~({DEPTH{1'b1}} << amt);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        shifted = word;
        take    = 1'b0;
        if (dir == DIR_LEFT) begin
            take = (word & top_mask) == '0;
            if (take) shifted = word << amt;
        end else begin
            take = (word & bot_mask) == '0;
            if (take) shifted = word >> amt;
        end
    end

endmodule

// File: rtl/shift_normalizer.sv
// Sequential normalizer: shifts the first set bit to the MSB over $clog2(DEPTH) cycles and reports the amount.
// Define NORM_DIR_EN to add in_dir and right (trailing-zero) normalization.
module shift_normalizer
    import norm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_normalizer_if.slave bus
);

    localparam int LOG2 = $clog2(DEPTH);
    localparam logic [LOG2-1:0] LAST_STAGE = LOG2'(LOG2 - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("shift_normalizer: DEPTH must be a power of two and >= 2");
    end

    norm_state_t       state;
    logic [DEPTH-1:0]  work;
    logic [LOG2-1:0]   shamt;
    logic [LOG2-1:0]   k;
    logic              stage_dir;
    logic [DEPTH-1:0]  stage_word;
    logic              stage_take;

    logic              in_ready_q;
    logic              out_valid_q;
    logic [DEPTH-1:0]  out_data_q;
    logic [LOG2-1:0]   out_shamt_q;
    logic              out_zero_q;

`ifdef NORM_DIR_EN
    logic dir_q;
    assign stage_dir = dir_q;
`else
    assign stage_dir = DIR_LEFT;
`endif

    // The single stage is time-multiplexed: k walks from the widest shift down to 1 bit.
    norm_stage #(
        .DEPTH (DEPTH)
    ) u_stage (
        .word    (work),
        .k       (k),
        .dir     (stage_dir),
        .shifted (stage_word),
        .take    (stage_take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            shamt       <= '0;
            k           <= '0;
`ifdef NORM_DIR_EN
            dir_q       <= DIR_LEFT;
`endif
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_shamt_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        work       <= bus.in_data;
                        shamt      <= '0;
                        k          <= LAST_STAGE;
`ifdef NORM_DIR_EN
                        dir_q      <= bus.in_dir;
`endif
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= stage_word;
                    if (stage_take) shamt[k] <= 1'b1;
                    if (k == '0) state <= DONE;
                    else         k     <= k - 1'b1;
                end
                DONE: begin
                    if (!out_valid_q) begin
                        // First DONE cycle publishes the result; it is held until the consumer takes it.
                        out_valid_q <= 1'b1;
                        out_data_q  <= work;
                        out_shamt_q <= shamt;
                        out_zero_q  <= (work == '0);
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_shamt = out_shamt_q;
    assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: vector table, hand-written corner sequences and a full input sweep.
// Expected results queue in a scoreboard at issue and are compared when the output handshake completes.
module tb_shift_normalizer;
    import norm_pkg::*;

    localparam int DEPTH = 8;
    localparam int LOG2  = 3;

    typedef struct {
        logic [DEPTH-1:0] data;
        logic [LOG2-1:0]  shamt;
        logic             zero;
    } exp_t;

    typedef struct {
        logic [DEPTH-1:0] in_data;
        logic             dir;
        logic [DEPTH-1:0] exp_data;
        logic [LOG2-1:0]  exp_shamt;
        logic             exp_zero;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    shift_normalizer_if #(.DEPTH(DEPTH)) bus ();

    shift_normalizer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: linear scan for the first set bit from the chosen end.
    function automatic exp_t model(input logic [DEPTH-1:0] d, input logic dir);
        exp_t r;
        int   n = 0;
        if (d == '0) begin
            r.data  = '0;
            r.shamt = LOG2'(DEPTH - 1);
            r.zero  = 1'b1;
            return r;
        end
        if (dir) begin
            while (!d[DEPTH-1-n]) n++;
            r.data = d << n;
        end else begin
            while (!d[n]) n++;
            r.data = d >> n;
        end
        r.shamt = LOG2'(n);
        r.zero  = 1'b0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [DEPTH-1:0] d, input logic [LOG2-1:0] s, input logic z);
        exp_t r;
        r.data  = d;
        r.shamt = s;
        r.zero  = z;
        return r;
    endfunction

    // Output monitor: samples just after the negedge, when the bench's drives have settled.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h with empty scoreboard", bus.out_data);
            end else begin
                mon_e = sb.pop_front();
                check("out_data",  32'(bus.out_data),  32'(mon_e.data));
                check("out_shamt", 32'(bus.out_shamt), 32'(mon_e.shamt));
                check("out_zero",  32'(bus.out_zero),  32'(mon_e.zero));
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DEPTH-1:0] d, input logic dir, input exp_t e);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef NORM_DIR_EN
        bus.in_dir   = dir;
`endif
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = DEPTH'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef NORM_DIR_EN
        bus.in_dir    = DIR_LEFT;
`endif

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_shamt", 32'(bus.out_shamt), 32'd0);
        check("rst_out_zero",  32'(bus.out_zero),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_state",    32'(dut.state),    32'(IDLE));

        // Latency: result visible after the 4th edge following acceptance
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'b0001_0110;
`ifdef NORM_DIR_EN
        bus.in_dir    = DIR_LEFT;
`endif
        sb.push_back(mk(8'b1011_0000, 3'd3, 1'b0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("lat_in_ready_e0", 32'(bus.in_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("lat_out_valid_early", 32'(bus.out_valid), 32'd0);
            check("lat_in_ready_busy",   32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        check("lat_out_valid_e4", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("lat_out_valid_e5", 32'(bus.out_valid), 32'd0);
        check("lat_in_ready_e5",  32'(bus.in_ready),  32'd1);
        drain();

        // Vector table
        tbl.push_back('{8'b0001_0110, DIR_LEFT, 8'b1011_0000, 3'd3, 1'b0});
        tbl.push_back('{8'b1011_0011, DIR_LEFT, 8'b1011_0011, 3'd0, 1'b0});
        tbl.push_back('{8'b0000_0000, DIR_LEFT, 8'b0000_0000, 3'd7, 1'b1});
        tbl.push_back('{8'b0000_0001, DIR_LEFT, 8'b1000_0000, 3'd7, 1'b0});
        tbl.push_back('{8'b0100_0000, DIR_LEFT, 8'b1000_0000, 3'd1, 1'b0});
        tbl.push_back('{8'b0000_1111, DIR_LEFT, 8'b1111_0000, 3'd4, 1'b0});
        tbl.push_back('{8'b1111_1111, DIR_LEFT, 8'b1111_1111, 3'd0, 1'b0});
        tbl.push_back('{8'b0010_1000, DIR_LEFT, 8'b1010_0000, 3'd2, 1'b0});
`ifdef NORM_DIR_EN
        tbl.push_back('{8'b1011_0000, DIR_RIGHT, 8'b0000_1011, 3'd4, 1'b0});
        tbl.push_back('{8'b0000_0000, DIR_RIGHT, 8'b0000_0000, 3'd7, 1'b1});
        tbl.push_back('{8'b0000_0001, DIR_RIGHT, 8'b0000_0001, 3'd0, 1'b0});
        tbl.push_back('{8'b1000_0000, DIR_RIGHT, 8'b0000_0001, 3'd7, 1'b0});
        tbl.push_back('{8'b0000_1100, DIR_RIGHT, 8'b0000_0011, 3'd2, 1'b0});
`endif
        foreach (tbl[i]) send(tbl[i].in_data, tbl[i].dir, mk(tbl[i].exp_data, tbl[i].exp_shamt, tbl[i].exp_zero));
        drain();

        // Backpressure: result held stable while out_ready is low
        bus.out_ready = 1'b0;
        send(8'b0000_0001, DIR_LEFT, mk(8'b1000_0000, 3'd7, 1'b0));
        begin
            int n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_data",  32'(bus.out_data),  32'h80);
            check("bp_out_shamt", 32'(bus.out_shamt), 32'd7);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_released_valid", 32'(bus.out_valid), 32'd0);
        check("bp_in_ready_back",  32'(bus.in_ready),  32'd1);
        check("bp_sb_empty",       32'(sb.size()),     32'd0);

        // Asynchronous reset during SHIFT
        send(8'b0000_0101, DIR_LEFT, model(8'b0000_0101, DIR_LEFT));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_state",     32'(dut.state),     32'(IDLE));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'b0100_0000, DIR_LEFT, mk(8'b1000_0000, 3'd1, 1'b0));
        drain();

        // Full sweep against the reference model
        for (int d = 0; d < 256; d++) send(8'(d), DIR_LEFT, model(8'(d), DIR_LEFT));
`ifdef NORM_DIR_EN
        for (int d = 0; d < 256; d++) send(8'(d), DIR_RIGHT, model(8'(d), DIR_RIGHT));
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
